// File: rtl/segre_recovery_unit_if.sv
// segre_recovery_unit_if: exception, history-file, register-file, CSR and redirect signals of the recovery unit
interface segre_recovery_unit_if #(
  parameter int REG_SIZE  = 5,
  parameter int WORD_SIZE = 32,
  parameter int ADDR_SIZE = 32
);
  logic                 exc_i;
  logic [3:0]           exc_cause_i;
  logic [ADDR_SIZE-1:0] exc_pc_i;
  logic [ADDR_SIZE-1:0] mtvec_i;
  logic                 hf_recovering_i;
  logic                 hf_empty_i;
  logic [REG_SIZE-1:0]  hf_dest_reg_i;
  logic [WORD_SIZE-1:0] hf_value_i;
  logic                 flush_o;
  logic                 stall_fetch_o;
  logic                 busy_o;
  logic                 rf_we_o;
  logic [REG_SIZE-1:0]  rf_waddr_o;
  logic [WORD_SIZE-1:0] rf_wdata_o;
  logic                 csr_we_o;
  logic [ADDR_SIZE-1:0] mepc_o;
  logic [3:0]           mcause_o;
  logic                 redirect_o;
  logic [ADDR_SIZE-1:0] redirect_pc_o;
  logic [7:0]           restored_cnt_o;
  logic                 wdog_o;
  modport slave (
    input  exc_i, exc_cause_i, exc_pc_i, mtvec_i,
    input  hf_recovering_i, hf_empty_i, hf_dest_reg_i, hf_value_i,
    output flush_o, stall_fetch_o, busy_o, rf_we_o, rf_waddr_o, rf_wdata_o,
    output csr_we_o, mepc_o, mcause_o, redirect_o, redirect_pc_o, restored_cnt_o, wdog_o
  );
  modport master (
    output exc_i, exc_cause_i, exc_pc_i, mtvec_i,
    output hf_recovering_i, hf_empty_i, hf_dest_reg_i, hf_value_i,
    input  flush_o, stall_fetch_o, busy_o, rf_we_o, rf_waddr_o, rf_wdata_o,
    input  csr_we_o, mepc_o, mcause_o, redirect_o, redirect_pc_o, restored_cnt_o, wdog_o
  );
endinterface

// File: rtl/segre_recovery_unit.sv
// segre_recovery_unit: precise-exception recovery (flush, history-file rollback, mepc/mcause write, trap redirect)
// Optional FLUSH watchdog enabled by defining RECOVERY_WATCHDOG_EN.
module segre_recovery_unit #(
  parameter int REG_SIZE    = 5,
  parameter int WORD_SIZE   = 32,
  parameter int ADDR_SIZE   = 32,
  parameter int WDOG_CYCLES = 16
) (
  input logic                   clk_i,
  input logic                   rst_i,
  segre_recovery_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, FLUSH, RESTORE, REDIRECT} state_e;
  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] mepc_q;
  logic [3:0]           mcause_q;
  logic [7:0]           cnt_q;
  logic                 wdog_q;
  logic                 wdog_trip;
  logic                 rf_we;
  logic                 unused_bits;
`ifdef RECOVERY_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wcnt_q;
  // counter is held at zero outside FLUSH, so it is clear on every FLUSH entry
  assign wdog_trip = state_q == FLUSH && !bus.hf_recovering_i && !bus.hf_empty_i &&
                     wcnt_q == WW'(WDOG_CYCLES - 1);
  always_ff @(posedge clk_i) begin
    wcnt_q <= (rst_i || state_q != FLUSH) ? '0 : wcnt_q + 1'b1;
    wdog_q <= rst_i ? 1'b0 : wdog_q | wdog_trip;
  end
  assign unused_bits = ^bus.mtvec_i[1:0];
`else
  assign wdog_trip   = 1'b0;
  assign wdog_q      = 1'b0;
  assign unused_bits = ^{bus.mtvec_i[1:0], WDOG_CYCLES};
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.exc_i ? FLUSH : IDLE;
      FLUSH:   state_d = bus.hf_recovering_i ? RESTORE :
                         (bus.hf_empty_i || wdog_trip) ? REDIRECT : FLUSH;
      RESTORE: state_d = bus.hf_recovering_i ? RESTORE : REDIRECT;
      default: state_d = IDLE;
    endcase
  end
  assign rf_we = state_q == RESTORE && bus.hf_recovering_i && !bus.hf_empty_i &&
                 bus.hf_dest_reg_i != '0;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      mepc_q   <= '0;
      mcause_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.exc_i) begin
        mepc_q   <= bus.exc_pc_i;
        mcause_q <= bus.exc_cause_i;
        cnt_q    <= '0;
      end else if (rf_we && cnt_q != 8'hFF) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end
  assign bus.busy_o         = state_q != IDLE;
  assign bus.stall_fetch_o  = state_q != IDLE;
  assign bus.flush_o        = state_q == FLUSH;
  assign bus.rf_we_o        = rf_we;
  assign bus.rf_waddr_o     = bus.hf_dest_reg_i;
  assign bus.rf_wdata_o     = bus.hf_value_i;
  assign bus.csr_we_o       = state_q == REDIRECT;
  assign bus.redirect_o     = state_q == REDIRECT;
  assign bus.redirect_pc_o  = state_q == REDIRECT ? {bus.mtvec_i[ADDR_SIZE-1:2], 2'b00} : '0;
  assign bus.mepc_o         = mepc_q;
  assign bus.mcause_o       = mcause_q;
  assign bus.restored_cnt_o = cnt_q;
  assign bus.wdog_o         = wdog_q;
endmodule

// File: tb/tb_segre_recovery_unit.sv
// tb_segre_recovery_unit: randomized episodes against a transaction-level model, checked by a scoreboard monitor
module tb_segre_recovery_unit;
  localparam int RS = 5, WS = 32, AS = 32, WD = 16;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;
  segre_recovery_unit_if #(.REG_SIZE(RS), .WORD_SIZE(WS), .ADDR_SIZE(AS)) bus ();
  segre_recovery_unit #(.REG_SIZE(RS), .WORD_SIZE(WS), .ADDR_SIZE(AS), .WDOG_CYCLES(WD)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus)
  );
  typedef struct {logic [RS-1:0] a; logic [WS-1:0] d;} wr_t;
  typedef struct {
    logic [AS-1:0] pc; logic [3:0] cause; logic [AS-1:0] rpc;
    logic [7:0] cnt; logic wdog; int flush; int busy;
  } red_t;
  wr_t  wr_q[$];
  red_t red_q[$];
  logic [RS-1:0] e_dest[$];
  logic [WS-1:0] e_val[$];
  bit            e_emp[$];
  int checks = 0, errors = 0;
  bit done = 0, wdog_m = 0;
  // scoreboard monitor
  int   busy_n = 0, flush_n = 0;
  bit   rst_prev = 0;
  wr_t  mw;
  red_t mr;
  always @(negedge clk_i) begin
    if (rst_prev) begin
      checks++;
      if ({bus.busy_o, bus.stall_fetch_o, bus.flush_o, bus.rf_we_o, bus.csr_we_o, bus.redirect_o,
           bus.redirect_pc_o, bus.mepc_o, bus.mcause_o, bus.restored_cnt_o, bus.wdog_o} !== '0) begin
        errors++;
        $display("FAIL reset_state busy=%0d rf_we=%0d redirect=%0d mepc=%h mcause=%0d cnt=%0d wdog=%0d required all 0",
                 bus.busy_o, bus.rf_we_o, bus.redirect_o, bus.mepc_o, bus.mcause_o, bus.restored_cnt_o, bus.wdog_o);
      end
    end
    rst_prev = rst_i;
    if (bus.busy_o) busy_n++;
    if (bus.flush_o) flush_n++;
    checks++;
    if (bus.stall_fetch_o !== bus.busy_o || bus.csr_we_o !== bus.redirect_o ||
        (!bus.redirect_o && bus.redirect_pc_o !== '0) || (bus.flush_o && !bus.busy_o)) begin
      errors++;
      $display("FAIL invariants busy=%0d stall=%0d csr_we=%0d redirect=%0d redirect_pc=%h flush=%0d",
               bus.busy_o, bus.stall_fetch_o, bus.csr_we_o, bus.redirect_o, bus.redirect_pc_o, bus.flush_o);
    end
    if (bus.rf_we_o === 1'b1) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL rf_write unexpected addr=%0d data=%h required none", bus.rf_waddr_o, bus.rf_wdata_o);
      end else begin
        mw = wr_q.pop_front();
        if (bus.rf_waddr_o !== mw.a || bus.rf_wdata_o !== mw.d) begin
          errors++;
          $display("FAIL rf_write got x%0d=%h required x%0d=%h", bus.rf_waddr_o, bus.rf_wdata_o, mw.a, mw.d);
        end
      end
    end
    if (bus.redirect_o === 1'b1) begin
      checks++;
      if (red_q.size() == 0) begin
        errors++;
        $display("FAIL redirect unexpected pc=%h required none", bus.redirect_pc_o);
      end else begin
        mr = red_q.pop_front();
        if (bus.redirect_pc_o !== mr.rpc || bus.mepc_o !== mr.pc || bus.mcause_o !== mr.cause ||
            bus.restored_cnt_o !== mr.cnt || bus.wdog_o !== mr.wdog || flush_n != mr.flush || busy_n != mr.busy) begin
          errors++;
          $display("FAIL redirect got rpc=%h mepc=%h cause=%0d cnt=%0d wdog=%0d flush=%0d busy=%0d required rpc=%h mepc=%h cause=%0d cnt=%0d wdog=%0d flush=%0d busy=%0d",
                   bus.redirect_pc_o, bus.mepc_o, bus.mcause_o, bus.restored_cnt_o, bus.wdog_o, flush_n, busy_n,
                   mr.rpc, mr.pc, mr.cause, mr.cnt, mr.wdog, mr.flush, mr.busy);
        end
      end
    end
    if (!bus.busy_o) begin
      busy_n = 0;
      flush_n = 0;
    end
    if (done) begin
      checks++;
      if (wr_q.size() != 0 || red_q.size() != 0) begin
        errors++;
        $display("FAIL leftover writes=%0d redirects=%0d required 0 0", wr_q.size(), red_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end
  initial begin
    #500000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end
  task automatic clr();
    e_dest.delete();
    e_val.delete();
    e_emp.delete();
  endtask
  task automatic add(input logic [RS-1:0] d, input logic [WS-1:0] v, input bit e);
    e_dest.push_back(d);
    e_val.push_back(v);
    e_emp.push_back(e);
  endtask
  task automatic quiet();
    bus.hf_recovering_i = 1'b0;
    bus.hf_empty_i      = 1'b0;
    bus.hf_dest_reg_i   = RS'($urandom);
    bus.hf_value_i      = $urandom;
  endtask
  // one recovery: expectations come from the restore list, then the stream is driven cycle by cycle
  task automatic episode(input logic [AS-1:0] pc, input logic [3:0] cause, input logic [AS-1:0] mtvec,
                         input int pre, input bit recov, input bit wd, input int rst_at, input bit dup);
    int   nw = 0;
    int   nf;
    wr_t  w;
    red_t r;
    nf = wd ? WD : pre;
    if (recov)
      for (int i = 0; i < e_dest.size(); i++)
        if (!e_emp[i] && e_dest[i] != 0 && (rst_at < 0 || i <= rst_at)) begin
          w.a = e_dest[i];
          w.d = e_val[i];
          wr_q.push_back(w);
          nw++;
        end
    if (wd) wdog_m = 1;
    if (rst_at < 0) begin
      r.pc = pc; r.cause = cause; r.rpc = mtvec & ~32'd3;
      r.cnt = nw > 255 ? 8'd255 : 8'(nw);
      r.wdog = wdog_m; r.flush = nf;
      r.busy = nf + (recov ? e_dest.size() + 1 : 0) + 1;
      red_q.push_back(r);
    end
    bus.exc_i = 1'b1; bus.exc_pc_i = pc; bus.exc_cause_i = cause; bus.mtvec_i = mtvec;
    quiet();
    @(posedge clk_i); #1;
    bus.exc_i = 1'b0; bus.exc_pc_i = $urandom; bus.exc_cause_i = 4'($urandom);
    if (wd) begin
      repeat (WD) begin @(posedge clk_i); #1; end
    end else begin
      repeat (pre - 1) begin @(posedge clk_i); #1; end
      bus.hf_recovering_i = recov;
      bus.hf_empty_i      = !recov;
      @(posedge clk_i); #1;
      if (recov) begin
        for (int i = 0; i < e_dest.size(); i++) begin
          bus.hf_recovering_i = 1'b1;
          bus.hf_empty_i      = e_emp[i];
          bus.hf_dest_reg_i   = e_dest[i];
          bus.hf_value_i      = e_val[i];
          if (dup && i == 0) begin bus.exc_i = 1'b1; bus.exc_pc_i = 32'h200; end
          if (i == rst_at) rst_i = 1'b1;
          @(posedge clk_i); #1;
          bus.exc_i = 1'b0;
          if (i == rst_at) begin
            rst_i = 1'b0;
            wdog_m = 0;
            quiet();
            return;
          end
        end
        bus.hf_recovering_i = 1'b0;
        bus.hf_empty_i      = 1'($urandom_range(0, 1));
        @(posedge clk_i); #1;
      end
    end
    quiet();
    @(posedge clk_i); #1;
  endtask
  initial begin
    bus.exc_i = 1'b0; bus.exc_cause_i = '0; bus.exc_pc_i = '0; bus.mtvec_i = '0;
    bus.hf_recovering_i = 1'b0; bus.hf_empty_i = 1'b0; bus.hf_dest_reg_i = '0; bus.hf_value_i = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    clr(); add(5, 32'hAA, 0); add(6, 32'hBB, 0); add(7, 32'hCC, 0);
    episode(32'h100, 4'd2, 32'h8000_0003, 1, 1, 0, -1, 0);
    clr(); add(0, 32'h55, 0); add(3, 32'h11, 0);
    episode(32'h104, 4'd3, 32'h0000_1001, 1, 1, 0, -1, 0);
    clr();
    episode(32'h108, 4'd4, 32'h2000_0002, 1, 0, 0, -1, 0);
    clr(); add(9, 32'h1, 0); add(10, 32'h2, 0);
    episode(32'h10C, 4'd5, 32'h0000_0000, 2, 1, 0, -1, 1);
    clr(); add(11, 32'h3, 0); add(12, 32'h4, 0); add(13, 32'h5, 0);
    episode(32'h300, 4'd6, 32'h4000_0000, 1, 1, 0, 1, 0);
    clr();
    for (int i = 0; i < 260; i++) add(RS'($urandom_range(1, 31)), $urandom, 0);
    episode(32'h400, 4'd9, 32'hFFFF_FFFF, 3, 1, 0, -1, 0);
`ifdef RECOVERY_WATCHDOG_EN
    clr();
    episode(32'h500, 4'd7, 32'h0000_0600, 1, 0, 1, -1, 0);
`else
    clr();
    episode(32'h500, 4'd7, 32'h0000_0600, 40, 0, 0, -1, 0);
`endif
    for (int k = 0; k < 40; k++) begin
      clr();
      for (int i = 0; i < int'($urandom_range(0, 6)); i++)
        add($urandom_range(0, 3) == 0 ? RS'(0) : RS'($urandom_range(1, 31)), $urandom, $urandom_range(0, 5) == 0);
      episode($urandom, 4'($urandom), $urandom, int'($urandom_range(1, 8)),
              $urandom_range(0, 3) != 0, 0, -1, 1'($urandom_range(0, 1)));
    end
    done = 1;
    forever @(posedge clk_i);
  end
endmodule
